// File: rtl/tm1638_byte_io.sv
// tm1638_byte_io: byte-wide serial shifter for the TM1638 (LSB first, sclk idles high).
// Revision 1.0
`default_nettype none

module tm1638_byte_io #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_latch,
  input  logic       rw,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       sclk,
  input  logic       dio_in,
  output logic       dio_out
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    bitn, bitn_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [7:0]    sh, sh_nx;
  logic [7:0]    data_rd_nx;
  logic          wr, wr_nx;
  logic          sclk_nx, dio_nx, busy_nx;
  logic          phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bitn    <= 3'd0;
      div_cnt <= '0;
      sh      <= 8'h00;
      wr      <= 1'b0;
      data_rd <= 8'h00;
      sclk    <= 1'b1;
      dio_out <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      bitn    <= bitn_nx;
      div_cnt <= div_nx;
      sh      <= sh_nx;
      wr      <= wr_nx;
      data_rd <= data_rd_nx;
      sclk    <= sclk_nx;
      dio_out <= dio_nx;
      busy    <= busy_nx;
    end
  end

  // Outputs are computed one cycle ahead so sclk/dio_out/busy leave flops directly.
  always_comb begin
    state_nx   = state;
    bitn_nx    = bitn;
    div_nx     = div_cnt;
    sh_nx      = sh;
    wr_nx      = wr;
    data_rd_nx = data_rd;
    sclk_nx    = sclk;
    dio_nx     = dio_out;
    busy_nx    = busy;
    case (state)
      IDLE: begin
        sclk_nx = 1'b1;
        dio_nx  = 1'b1;
        busy_nx = 1'b0;
        if (data_latch) begin
          wr_nx    = rw;
          sh_nx    = rw ? data_wr : 8'h00;
          bitn_nx  = 3'd0;
          div_nx   = '0;
          state_nx = LOW;
          sclk_nx  = 1'b0;
          busy_nx  = 1'b1;
          dio_nx   = rw ? data_wr[0] : 1'b1;
        end
      end
      LOW: begin
        if (phase_end) begin
          div_nx   = '0;
          state_nx = HIGH;
          sclk_nx  = 1'b1;
          // Sample on the rising sclk edge, after a full low phase of settling.
          if (!wr) sh_nx = {dio_in, sh[7:1]};
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          div_nx = '0;
          if (bitn == 3'd7) begin
            state_nx = IDLE;
            sclk_nx  = 1'b1;
            dio_nx   = 1'b1;
            busy_nx  = 1'b0;
            if (!wr) data_rd_nx = sh;
          end else begin
            bitn_nx  = bitn + 3'd1;
            state_nx = LOW;
            sclk_nx  = 1'b0;
            if (wr) begin
              sh_nx  = {1'b0, sh[7:1]};
              dio_nx = sh[1];
            end
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        sclk_nx  = 1'b1;
        dio_nx   = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tm1638_byte_io.sv
// Bench for tm1638_byte_io: two instances (CLK_DIV=1 and 2) checked against a transfer-level model.
`default_nettype none

module tb_tm1638_byte_io;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] latch_a = '0;
  logic [1:0] rw_a = '0;
  logic [1:0] dio_in_a = '1;
  logic [7:0] dwr_a [2];
  logic [7:0] rd_o [2];
  logic [1:0] busy_o, sclk_o, dio_o;
  logic [7:0] exp_rd [2];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tm1638_byte_io #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .data_latch(latch_a[0]), .rw(rw_a[0]), .data_wr(dwr_a[0]),
    .data_rd(rd_o[0]), .busy(busy_o[0]), .sclk(sclk_o[0]), .dio_in(dio_in_a[0]), .dio_out(dio_o[0])
  );

  tm1638_byte_io #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .data_latch(latch_a[1]), .rw(rw_a[1]), .data_wr(dwr_a[1]),
    .data_rd(rd_o[1]), .busy(busy_o[1]), .sclk(sclk_o[1]), .dio_in(dio_in_a[1]), .dio_out(dio_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte transfer on instance s (0: CLK_DIV=1, 1: CLK_DIV=2). Called at a negedge
  // with the instance idle; returns at the negedge of the first busy-low cycle.
  task automatic xfer(input int s, input bit w, input logic [7:0] b, input bit hold, input bit glitch);
    int cd = s + 1;
    int n = 0, pulses = 0, lowrun = 0, badw = 0, badd = 0, badhi = 0, bi = 0, rise = 0;
    logic [7:0] got = 8'h00;
    logic ps = 1'b1, pd = 1'b1;
    bit done = 1'b0;
    rw_a[s]    = w;
    dwr_a[s]   = w ? b : 8'($urandom);
    latch_a[s] = 1'b1;
    @(negedge clk);
    chk("start_busy", 32'(busy_o[s]), 32'd1);
    for (int k = 0; k < 16 * cd + 8 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (busy_o[s]) begin
        n++;
        if (!sclk_o[s]) lowrun++;
        if (ps && !sclk_o[s]) begin
          if (!w && bi < 8) dio_in_a[s] = b[bi];
          bi++;
        end
        if (!ps && sclk_o[s]) begin
          if (lowrun != cd) badw++;
          lowrun = 0;
          pulses++;
          if (rise < 8) got[rise] = dio_o[s];
          rise++;
        end
        if (dio_o[s] !== pd && !(ps && !sclk_o[s])) badd++;
        if (!w && dio_o[s] !== 1'b1) badhi++;
        if (!hold) begin
          latch_a[s] = glitch && (n == 5 || n == 20);
          rw_a[s]    = ~w;
          dwr_a[s]   = ~b;
        end
      end else begin
        done = 1'b1;
      end
      ps = sclk_o[s];
      pd = dio_o[s];
    end
    chk("done_in_time", 32'(done), 32'd1);
    chk("busy_len", n, 16 * cd);
    chk("sclk_pulses", pulses, 8);
    chk("low_width_errs", badw, 0);
    chk("dio_change_errs", badd, 0);
    if (w) chk("bits_out", 32'(got), 32'(b));
    else begin
      chk("read_dio_high", badhi, 0);
      exp_rd[s] = b;
    end
    chk("data_rd", 32'(rd_o[s]), 32'(exp_rd[s]));
    chk("idle_sclk", 32'(sclk_o[s]), 32'd1);
  endtask

  initial begin
    dwr_a[0]  = 8'h00;
    dwr_a[1]  = 8'h00;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_sclk", 32'(sclk_o[s]), 32'd1);
      chk("rst_dio", 32'(dio_o[s]), 32'd1);
      chk("rst_busy", 32'(busy_o[s]), 32'd0);
      chk("rst_data_rd", 32'(rd_o[s]), 32'h00);
    end
    rst = 1'b0;
    @(negedge clk);

    xfer(1, 1'b1, 8'hA5, 1'b0, 1'b0);
    xfer(1, 1'b0, 8'h3C, 1'b0, 1'b0);
    xfer(1, 1'b1, 8'($urandom), 1'b0, 1'b1);

    // Abort a read at bit 4 with reset.
    rw_a[1] = 1'b0;
    latch_a[1] = 1'b1;
    @(negedge clk);
    latch_a[1] = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    chk("abort_sclk", 32'(sclk_o[1]), 32'd1);
    chk("abort_busy", 32'(busy_o[1]), 32'd0);
    chk("abort_dio", 32'(dio_o[1]), 32'd1);
    chk("abort_data_rd", 32'(rd_o[1]), 32'h00);
    @(negedge clk);
    xfer(1, 1'b0, 8'h81, 1'b0, 1'b0);

    xfer(1, 1'b1, 8'h40, 1'b1, 1'b0);
    xfer(1, 1'b1, 8'hC0, 1'b1, 1'b0);
    xfer(1, 1'b1, 8'h40, 1'b1, 1'b0);
    xfer(1, 1'b1, 8'hC0, 1'b0, 1'b0);

    xfer(0, 1'b1, 8'hFF, 1'b0, 1'b0);
    xfer(0, 1'b1, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'($urandom), 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 1'b0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tm1638_byte_io.md
# tm1638_byte_io

Byte-level serial engine for the TM1638 display/key controller. It sits between the board-level display sequencer and the TM1638 pins. It accepts one byte per `data_latch` pulse, then does one of two things. For a write, it shifts the byte out LSB-first on `dio_out` with a generated `sclk`. For a read, it shifts a byte in from `dio_in`. Chip select and tristate control belong to the sequencer; this block never drives `tm_cs` and never enables the pad.

## Interface
Parameters:
- `CLK_DIV`, default 16: system clocks per `sclk` half-period. Legal range is ≥1. With 27 MHz and 16, `sclk` is ≈0.84 MHz.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data_latch`, in, 1: start request. It is sampled only in IDLE.
- `rw`, in, 1: 1 = write byte, 0 = read byte. It is captured at accept.
- `data_wr`, in, 8: byte to send. It is captured at accept when `rw`=1.
- `data_rd`, out, 8: last byte read, LSB = first bit received.
- `busy`, out, 1: high while a transfer is in progress.
- `sclk`, out, 1: serial clock to TM1638. It idles high.
- `dio_in`, in, 1: serial data from the pad.
- `dio_out`, out, 1: serial data to the pad.

## Operation
- States: IDLE, LOW, HIGH. There is a bit counter `bitn` (0..7), a phase counter `div_cnt` (0..CLK_DIV-1), and an 8-bit shift register `sh`.
- IDLE: `sclk`=1, `dio_out`=1, `busy`=0.
  - If `data_latch`=1, accept the request: `sh` ← `data_wr` (write) or 0 (read), store `rw`, set `bitn` ← 0 and `div_cnt` ← 0, go to LOW.
- LOW:
  - Outputs: `sclk`=0, `busy`=1.
  - `dio_out` = `sh[0]` for a write and 1 for a read.
  - After CLK_DIV cycles, go to HIGH.
  - On the edge leaving LOW during a read, shift `dio_in` into `sh[7]` (`sh` ← {`dio_in`, `sh[7:1]`}).
- HIGH:
  - Outputs: `sclk`=1, `busy`=1, `dio_out` holds its value.
  - After CLK_DIV cycles:
    - If `bitn`=7, go to IDLE. For a read, `data_rd` ← `sh`.
    - Otherwise shift `sh` right for a write, increment `bitn`, and go to LOW.
- Write transactions never modify `data_rd`. `data_rd` holds its value until the next read completes.
- `data_latch` while `busy`=1 is ignored, with no queuing. A latch held high across the end of a transfer is accepted again on the first IDLE cycle.
- `rw` and `data_wr` changes after accept have no effect.
- The inter-byte wait required by TM1638 is not inserted here; the sequencer provides it. An example is the wait after the read command before the first read byte.

## Timing
- Reset values: `sclk`=1, `dio_out`=1, `busy`=0, `data_rd`=8'h00, state IDLE.
- Reset mid-transfer: the next cycle shows IDLE outputs. No partial `data_rd` update occurs.
- Accept cycle T0: `busy` is still 0 in T0.
  - `busy`=1 and `sclk`=0 from T1.
  - The transfer occupies T1..T(16·CLK_DIV).
  - `busy`=0 in cycle T(16·CLK_DIV+1), and `data_rd` is valid in that same cycle.
- `dio_out` changes only on the cycle `sclk` falls. This gives CLK_DIV clocks of setup before the rising edge.
- A read bit is sampled on the clock edge where `sclk` goes 0→1. This is after CLK_DIV clocks of low phase, so the TM1638 output has settled.
- Back-to-back throughput: a new accept is possible in the cycle `busy` falls. The minimum period is 16·CLK_DIV+1 clocks per byte.
- `sclk` and `dio_out` come straight from registers, with no combinational path from inputs.

## Test plan
- Write 0xA5, CLK_DIV=2: `busy` stays high 32 cycles. `dio_out` sampled at each `sclk` rise reads 1,0,1,0,0,1,0,1. There are exactly 8 `sclk` low pulses of 2 cycles each. `data_rd` stays 0x00.
- Read with a bench TM1638 model driving 0x3C LSB-first, changing on `sclk` fall, CLK_DIV=2: `data_rd`=0x3C in the cycle `busy` falls, and `dio_out`=1 throughout.
- Latch pulses at cycles 5 and 20 of an active write, CLK_DIV=2: both are ignored. The byte shifted out is unchanged and `busy` is 32 cycles.
- Assert `rst` at bit 4 of a read: next cycle `sclk`=1, `busy`=0, `dio_out`=1, and `data_rd`=0x00. A subsequent full read of 0x81 returns 0x81.
- `data_latch` held high continuously, alternating `data_wr` 0x40/0xC0: each transfer runs 16·CLK_DIV cycles, then exactly one `busy`-low cycle, then the next transfer starts. Each byte is correct.
- CLK_DIV=1 edge case, write 0xFF then 0x00: the `sclk` period is 2 clocks, `busy` is 16 cycles per byte, and `dio_out` levels are correct.
